// File: rtl/seq_alu_pkg.sv
// ---------------------------------------------------------------------------
// seq_alu_pkg
// Shared types for the sequential ALU/accumulator block.
//   alu_func_t : 3-bit operation select driven on the Function port.
//   state_t    : top-level control state (idle, or iterative multiply busy).
// ---------------------------------------------------------------------------
package seq_alu_pkg;

    typedef enum logic [2:0] {
        ADD  = 3'd0,
        MUL  = 3'd1,
        SHL  = 3'd2,
        HOLD = 3'd3,
        SUB  = 3'd4,
        SHR  = 3'd5,
        LOAD = 3'd6,
        CLR  = 3'd7
    } alu_func_t;

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// shift_add_multiplier
// Unsigned DATA_W x DATA_W multiplier, one partial-product step per clock.
// Ports:
//   Clock   : rising-edge clock
//   Reset_b : synchronous, active-high reset (aborts any multiply in flight)
//   start   : latch a/b and begin; ignored while busy
//   a, b    : multiplicand and multiplier
//   busy    : a multiply is in progress
//   done    : high during the last step; product is valid in that cycle
//   product : final product, meaningful only while done is high
// A multiply started at edge E0 performs its steps at edges E1..E_DATA_W;
// done/product are presented combinationally so the consumer can capture
// the result at the same edge that performs the final step.
// ---------------------------------------------------------------------------
module shift_add_multiplier #(
    parameter int DATA_W = 4
) (
    input  logic                Clock,
    input  logic                Reset_b,
    input  logic                start,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic                busy,
    output logic                done,
    output logic [2*DATA_W-1:0] product
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [2*DATA_W-1:0] mcand;
    logic [2*DATA_W-1:0] partial;
    logic [2*DATA_W-1:0] partial_next;
    logic [DATA_W-1:0]   mplier;
    logic [CNT_W-1:0]    steps_left;

    assign partial_next = mplier[0] ? (partial + mcand) : partial;
    assign done         = busy && (steps_left == CNT_W'(1));
    assign product      = partial_next;

    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values; blocking here would chain the updates.
    always_ff @(posedge Clock) begin
        if (Reset_b) begin
            busy       <= 1'b0;
            steps_left <= '0;
            mcand      <= '0;
            mplier     <= '0;
            partial    <= '0;
        end else if (start && !busy) begin
            busy       <= 1'b1;
            steps_left <= CNT_W'(DATA_W);
            mcand      <= (2*DATA_W)'(a);
            mplier     <= b;
            partial    <= '0;
        end else if (busy) begin
            partial    <= partial_next;
            mcand      <= mcand << 1;
            mplier     <= mplier >> 1;
            steps_left <= steps_left - CNT_W'(1);
            if (steps_left == CNT_W'(1)) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_alu_acc.sv
// ---------------------------------------------------------------------------
// seq_alu_acc
// Sequential ALU with a 2*DATA_W-bit accumulator. Each accepted operation
// combines operand Data with the low half of the accumulator and commits the
// result back to the accumulator.
// Ports:
//   Clock       : rising-edge clock
//   Reset_b     : synchronous, active-high reset
//   in_valid    : operation request
//   in_ready    : block can accept an operation (combinational)
//   Data        : operand A
//   Function    : operation select (alu_func_t)
//   ALU_reg_out : accumulator (registered)
//   out_valid   : one-cycle pulse the cycle after each commit (registered)
//   carry       : carry/borrow of the last ADD/SUB (registered)
//   zero        : accumulator is zero (combinational)
// With MUL_ITERATIVE=1 a MUL occupies the block for DATA_W cycles and the
// accumulator keeps its old value until the product is committed.
// ---------------------------------------------------------------------------
module seq_alu_acc
    import seq_alu_pkg::*;
#(
    parameter int DATA_W        = 4,
    parameter int ACC_W         = 2 * DATA_W,
    parameter int MUL_ITERATIVE = 1
) (
    input  logic              Clock,
    input  logic              Reset_b,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] Data,
    input  alu_func_t         Function,
    output logic [ACC_W-1:0]  ALU_reg_out,
    output logic              out_valid,
    output logic              carry,
    output logic              zero
);

    // Shift amounts at or beyond the accumulator width flush to zero.
    localparam logic [DATA_W:0] SHIFT_LIMIT = (DATA_W + 1)'(ACC_W);

    state_t           state;
    logic             accept;
    logic             shift_oob;
    logic [ACC_W-1:0] a_ext;
    logic [ACC_W-1:0] b_ext;
    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] result;
    logic             result_carry;
    logic             mul_busy;
    logic             mul_done;
    logic [ACC_W-1:0] mul_product;

    assign in_ready  = (state == IDLE) && !Reset_b;
    assign accept    = in_valid && in_ready;
    assign zero      = (ALU_reg_out == '0);
    assign a_ext     = ACC_W'(Data);
    assign b_ext     = ACC_W'(ALU_reg_out[DATA_W-1:0]);
    assign sum       = a_ext + b_ext;
    assign shift_oob = ({1'b0, Data} >= SHIFT_LIMIT);

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        result       = ALU_reg_out;
        result_carry = carry;
        unique case (Function)
            ADD: begin
                result       = sum;
                result_carry = sum[DATA_W];
            end
            MUL: begin
                result       = a_ext * b_ext;
                result_carry = 1'b0;
            end
            SHL: begin
                result       = shift_oob ? '0 : (b_ext << Data);
                result_carry = 1'b0;
            end
            HOLD: begin
                result       = ALU_reg_out;
                result_carry = carry;
            end
            SUB: begin
                result       = b_ext - a_ext;
                result_carry = (Data > ALU_reg_out[DATA_W-1:0]);
            end
            SHR: begin
                result       = shift_oob ? '0 : (ALU_reg_out >> Data);
                result_carry = 1'b0;
            end
            LOAD: begin
                result       = a_ext;
                result_carry = 1'b0;
            end
            CLR: begin
                result       = '0;
                result_carry = 1'b0;
            end
        endcase
    end

    generate
        if (MUL_ITERATIVE != 0) begin : g_iter_mul
            logic mul_start;
            assign mul_start = accept && (Function == MUL);

            shift_add_multiplier #(
                .DATA_W (DATA_W)
            ) u_mul (
                .Clock   (Clock),
                .Reset_b (Reset_b),
                .start   (mul_start),
                .a       (Data),
                .b       (ALU_reg_out[DATA_W-1:0]),
                .busy    (mul_busy),
                .done    (mul_done),
                .product (mul_product)
            );
        end else begin : g_comb_mul
            assign mul_busy    = 1'b0;
            assign mul_done    = 1'b0;
            assign mul_product = '0;
        end
    endgenerate

    always_ff @(posedge Clock) begin
        if (Reset_b) begin
            ALU_reg_out <= '0;
            out_valid   <= 1'b0;
            carry       <= 1'b0;
            state       <= IDLE;
        end else begin
            out_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if ((MUL_ITERATIVE != 0) && (Function == MUL)) begin
                            state <= MUL_BUSY;
                        end else begin
                            ALU_reg_out <= result;
                            carry       <= result_carry;
                            out_valid   <= 1'b1;
                        end
                    end
                end
                MUL_BUSY: begin
                    if (mul_done) begin
                        ALU_reg_out <= mul_product;
                        carry       <= 1'b0;
                        out_valid   <= 1'b1;
                        state       <= IDLE;
                    end else if (!mul_busy) begin
                        // Multiplier idle without finishing: never wait forever.
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu_acc.sv
// ---------------------------------------------------------------------------
// tb_seq_alu_acc
// Self-checking bench for seq_alu_acc. dut0: DATA_W=4, iterative multiply.
// dut1: DATA_W=8, single-cycle multiply. Single-cycle operations on dut0 are
// driven from a vector table; multi-cycle multiply and reset-abort are
// hand-written sequences. Every commit of dut0 is matched against a queue of
// expected {accumulator, carry} values.
// ---------------------------------------------------------------------------
module tb_seq_alu_acc;
    import seq_alu_pkg::*;

    typedef struct {
        alu_func_t  func;
        logic [3:0] data;
        logic [7:0] acc;
        logic       cy;
        logic       zr;
    } vec_t;

    typedef struct packed {
        logic [7:0] acc;
        logic       cy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst0, iv0, ir0, ov0, c0, z0;
    logic [3:0]  data0;
    alu_func_t   func0;
    logic [7:0]  acc0;
    logic        rst1, iv1, ir1, ov1, c1, z1;
    logic [7:0]  data1;
    alu_func_t   func1;
    logic [15:0] acc1;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    exp_t sb_head;
    vec_t vecs[$];

    always #5 clk = ~clk;

    seq_alu_acc #(.DATA_W(4), .ACC_W(8), .MUL_ITERATIVE(1)) dut0 (
        .Clock       (clk),
        .Reset_b     (rst0),
        .in_valid    (iv0),
        .in_ready    (ir0),
        .Data        (data0),
        .Function    (func0),
        .ALU_reg_out (acc0),
        .out_valid   (ov0),
        .carry       (c0),
        .zero        (z0)
    );

    seq_alu_acc #(.DATA_W(8), .ACC_W(16), .MUL_ITERATIVE(0)) dut1 (
        .Clock       (clk),
        .Reset_b     (rst1),
        .in_valid    (iv1),
        .in_ready    (ir1),
        .Data        (data1),
        .Function    (func1),
        .ALU_reg_out (acc1),
        .out_valid   (ov1),
        .carry       (c1),
        .zero        (z1)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drive one dut0 operation for a single edge and queue its expected commit.
    task automatic issue0(input alu_func_t f, input logic [3:0] d, input logic [7:0] ea, input logic ec);
        func0 = f;
        data0 = d;
        iv0   = 1'b1;
        sb.push_back('{acc: ea, cy: ec});
        @(posedge clk);
        #1;
        iv0 = 1'b0;
    endtask

    // Scoreboard: every out_valid pulse of dut0 must match the oldest expectation.
    always @(negedge clk) begin
        if (ov0 === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected_out_valid: got acc 0x%0h, expected no commit (t=%0t)", acc0, $time);
            end else begin
                sb_head = sb.pop_front();
                check("sb_acc", 32'(acc0), 32'(sb_head.acc));
                check("sb_carry", 32'(c0), 32'(sb_head.cy));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs.push_back('{LOAD, 4'd5,  8'h05, 1'b0, 1'b0});
        vecs.push_back('{ADD,  4'd7,  8'h0C, 1'b0, 1'b0});
        vecs.push_back('{LOAD, 4'd15, 8'h0F, 1'b0, 1'b0});
        vecs.push_back('{ADD,  4'd15, 8'h1E, 1'b1, 1'b0});
        vecs.push_back('{HOLD, 4'd9,  8'h1E, 1'b1, 1'b0});
        vecs.push_back('{CLR,  4'd0,  8'h00, 1'b0, 1'b1});
        vecs.push_back('{LOAD, 4'd3,  8'h03, 1'b0, 1'b0});
        vecs.push_back('{SHL,  4'd4,  8'h30, 1'b0, 1'b0});
        vecs.push_back('{SHR,  4'd4,  8'h03, 1'b0, 1'b0});
        vecs.push_back('{LOAD, 4'd3,  8'h03, 1'b0, 1'b0});
        vecs.push_back('{SHL,  4'd9,  8'h00, 1'b0, 1'b1});
        vecs.push_back('{LOAD, 4'd2,  8'h02, 1'b0, 1'b0});
        vecs.push_back('{SUB,  4'd5,  8'hFD, 1'b1, 1'b0});
        vecs.push_back('{LOAD, 4'd9,  8'h09, 1'b0, 1'b0});
        vecs.push_back('{SUB,  4'd4,  8'h05, 1'b0, 1'b0});
        vecs.push_back('{SUB,  4'd5,  8'h00, 1'b0, 1'b1});
        vecs.push_back('{LOAD, 4'd1,  8'h01, 1'b0, 1'b0});
        vecs.push_back('{SHL,  4'd7,  8'h80, 1'b0, 1'b0});
        vecs.push_back('{ADD,  4'd3,  8'h03, 1'b0, 1'b0});
        vecs.push_back('{LOAD, 4'd12, 8'h0C, 1'b0, 1'b0});
        vecs.push_back('{SHL,  4'd3,  8'h60, 1'b0, 1'b0});
        vecs.push_back('{SHR,  4'd8,  8'h00, 1'b0, 1'b1});
        vecs.push_back('{LOAD, 4'd15, 8'h0F, 1'b0, 1'b0});
        vecs.push_back('{SHL,  4'd4,  8'hF0, 1'b0, 1'b0});
        vecs.push_back('{SHR,  4'd7,  8'h01, 1'b0, 1'b0});
        vecs.push_back('{LOAD, 4'd15, 8'h0F, 1'b0, 1'b0});
        vecs.push_back('{ADD,  4'd15, 8'h1E, 1'b1, 1'b0});
        vecs.push_back('{SHL,  4'd1,  8'h1C, 1'b0, 1'b0});

        rst0 = 1'b1; iv0 = 1'b0; data0 = '0; func0 = HOLD;
        rst1 = 1'b1; iv1 = 1'b0; data1 = '0; func1 = HOLD;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_acc", 32'(acc0), 32'h0);
        check("rst_out_valid", 32'(ov0), 32'h0);
        check("rst_carry", 32'(c0), 32'h0);
        check("rst_zero", 32'(z0), 32'h1);
        check("rst_in_ready", 32'(ir0), 32'h0);
        check("rst_acc_w8", 32'(acc1), 32'h0);
        rst0 = 1'b0;
        rst1 = 1'b0;
        #1;
        check("ready_after_rst", 32'(ir0), 32'h1);

        // Single-cycle operations issued back to back
        foreach (vecs[i]) begin
            issue0(vecs[i].func, vecs[i].data, vecs[i].acc, vecs[i].cy);
            check($sformatf("vec%0d_acc", i), 32'(acc0), 32'(vecs[i].acc));
            check($sformatf("vec%0d_carry", i), 32'(c0), 32'(vecs[i].cy));
            check($sformatf("vec%0d_zero", i), 32'(z0), 32'(vecs[i].zr));
            check($sformatf("vec%0d_out_valid", i), 32'(ov0), 32'h1);
            check($sformatf("vec%0d_in_ready", i), 32'(ir0), 32'h1);
        end
        @(posedge clk);
        #1;
        check("idle_no_out_valid", 32'(ov0), 32'h0);

        // Iterative multiply with an ADD held pending during busy
        issue0(LOAD, 4'd13, 8'h0D, 1'b0);
        func0 = MUL;
        data0 = 4'd11;
        iv0   = 1'b1;
        sb.push_back('{acc: 8'h8F, cy: 1'b0});
        @(posedge clk);
        #1;
        func0 = ADD;
        data0 = 4'd1;
        sb.push_back('{acc: 8'h10, cy: 1'b1});
        for (int k = 0; k < 4; k++) begin
            check($sformatf("mul_busy%0d_in_ready", k), 32'(ir0), 32'h0);
            check($sformatf("mul_busy%0d_acc", k), 32'(acc0), 32'h0D);
            check($sformatf("mul_busy%0d_out_valid", k), 32'(ov0), 32'h0);
            @(posedge clk);
            #1;
        end
        check("mul_commit_acc", 32'(acc0), 32'h8F);
        check("mul_commit_out_valid", 32'(ov0), 32'h1);
        check("mul_commit_in_ready", 32'(ir0), 32'h1);
        check("mul_commit_carry", 32'(c0), 32'h0);
        @(posedge clk);
        #1;
        iv0 = 1'b0;
        check("held_add_acc", 32'(acc0), 32'h10);
        check("held_add_carry", 32'(c0), 32'h1);
        check("held_add_out_valid", 32'(ov0), 32'h1);
        @(posedge clk);
        #1;
        check("held_add_once_out_valid", 32'(ov0), 32'h0);
        check("held_add_once_acc", 32'(acc0), 32'h10);

        // Reset in the second busy cycle aborts the multiply
        issue0(LOAD, 4'd9, 8'h09, 1'b0);
        func0 = MUL;
        data0 = 4'd9;
        iv0   = 1'b1;
        @(posedge clk);
        #1;
        iv0 = 1'b0;
        check("abort_busy_in_ready", 32'(ir0), 32'h0);
        @(posedge clk);
        #1;
        rst0 = 1'b1;
        #1;
        check("abort_rst_in_ready", 32'(ir0), 32'h0);
        @(posedge clk);
        #1;
        check("abort_acc", 32'(acc0), 32'h0);
        check("abort_out_valid", 32'(ov0), 32'h0);
        check("abort_zero", 32'(z0), 32'h1);
        check("abort_carry", 32'(c0), 32'h0);
        rst0 = 1'b0;
        #1;
        check("abort_release_in_ready", 32'(ir0), 32'h1);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("abort_quiet%0d_acc", k), 32'(acc0), 32'h0);
        end
        issue0(LOAD, 4'd1, 8'h01, 1'b0);
        check("post_abort_load_acc", 32'(acc0), 32'h01);
        check("post_abort_load_out_valid", 32'(ov0), 32'h1);

        // Single-cycle multiply, DATA_W=8
        func1 = LOAD;
        data1 = 8'd200;
        iv1   = 1'b1;
        @(posedge clk);
        #1;
        check("w8_load_acc", 32'(acc1), 32'd200);
        check("w8_load_out_valid", 32'(ov1), 32'h1);
        func1 = MUL;
        @(posedge clk);
        #1;
        check("w8_mul_acc", 32'(acc1), 32'h9C40);
        check("w8_mul_out_valid", 32'(ov1), 32'h1);
        check("w8_mul_in_ready", 32'(ir1), 32'h1);
        check("w8_mul_carry", 32'(c1), 32'h0);
        func1 = ADD;
        data1 = 8'hC0;
        @(posedge clk);
        #1;
        iv1 = 1'b0;
        check("w8_add_acc", 32'(acc1), 32'h0100);
        check("w8_add_carry", 32'(c1), 32'h1);
        @(posedge clk);
        #1;
        check("w8_idle_out_valid", 32'(ov1), 32'h0);

        @(posedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
